wb_write_queue: RTL



---
 rtl/wb_write_queue_if.sv | 41 ++++
 rtl/wb_write_queue.sv | 126 ++++++++++++
 2 files changed

// File: rtl/wb_write_queue_if.sv
// Bus bundle for the write-back queue: two producer handshakes, the regfile
// write port and the two forwarding lookup ports.
interface wb_write_queue_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    // valid/ready: a transfer fires on a rising clock edge where valid & ready
    // are both high; the producer holds valid, rd and data stable until it fires.
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          md_valid;
    logic          md_ready;
    logic [AW-1:0] md_rd;
    logic [DW-1:0] md_data;
    logic          ctrl_writeEnable;
    logic [AW-1:0] ctrl_writeReg;
    logic [DW-1:0] data_writeReg;
    logic [AW-1:0] fwd_addrA;
    logic          fwd_hitA;
    logic [DW-1:0] fwd_dataA;
    logic [AW-1:0] fwd_addrB;
    logic          fwd_hitB;
    logic [DW-1:0] fwd_dataB;
    logic          wbq_empty;

    modport slave (
        input  wb_valid, wb_rd, wb_data, md_valid, md_rd, md_data,
        input  fwd_addrA, fwd_addrB,
        output wb_ready, md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output fwd_hitA, fwd_dataA, fwd_hitB, fwd_dataB, wbq_empty
    );

    modport master (
        output wb_valid, wb_rd, wb_data, md_valid, md_rd, md_data,
        output fwd_addrA, fwd_addrB,
        input  wb_ready, md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  fwd_hitA, fwd_dataA, fwd_hitB, fwd_dataB, wbq_empty
    );
endinterface

// File: rtl/wb_write_queue.sv
// Write-back queue owning the regfile write port: merges pipeline and mult/div
// writes in order, retires one per cycle and forwards pending values to decode.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input logic              clock,
    input logic              ctrl_reset,
    wb_write_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [AW-1:0] rd_mem_q   [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];
    logic          we_q, we_d;
    logic [AW-1:0] wreg_q, wreg_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic [CW-1:0] free;
    logic          md_ready_w, wb_ready_w;
    logic          md_enq, wb_enq, deq;
    logic [PW-1:0] wb_slot;
    logic [DW:0]   fwd_a, fwd_b;

    // free counts slots before this edge's pop, so a pop never makes room
    // for a push in the same cycle.
    assign free       = CW'(DEPTH) - count_q;
    assign md_ready_w = (free != '0);
    assign wb_ready_w = (free >= (CW'(1) + CW'(bus.md_valid)));

    // rd==0 completes the handshake but is dropped here.
    assign md_enq  = bus.md_valid & md_ready_w & (bus.md_rd != '0);
    assign wb_enq  = bus.wb_valid & wb_ready_w & (bus.wb_rd != '0);
    assign deq     = (count_q != '0);
    assign wb_slot = tail_q + PW'(md_enq);

    always_comb begin
        count_d = count_q + CW'(md_enq) + CW'(wb_enq) - CW'(deq);
        tail_d  = tail_q + PW'(md_enq) + PW'(wb_enq);
        head_d  = head_q + PW'(deq);
        we_d    = deq;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (deq) begin
            wreg_d  = rd_mem_q[head_q];
            wdata_d = data_mem_q[head_q];
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    // Entry storage needs no reset; only slots inside [head, head+count) are read.
    always_ff @(posedge clock) begin
        if (md_enq) begin
            rd_mem_q[tail_q]   <= bus.md_rd;
            data_mem_q[tail_q] <= bus.md_data;
        end
        if (wb_enq) begin
            rd_mem_q[wb_slot]   <= bus.wb_rd;
            data_mem_q[wb_slot] <= bus.wb_data;
        end
    end

    // Scan oldest to youngest so the youngest match overrides; the presented
    // output register is older than every queued entry.
    function automatic logic [DW:0] fwd_lookup(input logic [AW-1:0] addr);
        logic          hit;
        logic [DW-1:0] data;
        logic [PW-1:0] idx;
        hit  = 1'b0;
        data = '0;
        if (we_q && (wreg_q == addr)) begin
            hit  = 1'b1;
            data = wdata_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (rd_mem_q[idx] == addr)) begin
                hit  = 1'b1;
                data = data_mem_q[idx];
            end
        end
        if (addr == '0) begin
            hit  = 1'b0;
            data = '0;
        end
        return {hit, data};
    endfunction

    always_comb begin
        fwd_a = fwd_lookup(bus.fwd_addrA);
        fwd_b = fwd_lookup(bus.fwd_addrB);
    end

    assign bus.md_ready         = md_ready_w;
    assign bus.wb_ready         = wb_ready_w;
    assign bus.ctrl_writeEnable = we_q;
    assign bus.ctrl_writeReg    = wreg_q;
    assign bus.data_writeReg    = wdata_q;
    assign bus.fwd_hitA         = fwd_a[DW];
    assign bus.fwd_dataA        = fwd_a[DW-1:0];
    assign bus.fwd_hitB         = fwd_b[DW];
    assign bus.fwd_dataB        = fwd_b[DW-1:0];
    assign bus.wbq_empty        = (count_q == '0) & ~we_q;
endmodule
